countdown_timer_core: RTL and testbench



---
 rtl/timer_defs.sv | 29 ++
 rtl/bcd_digit_updown.sv | 33 +++
 rtl/countdown_timer_core.sv | 142 ++++++++++++++
 tb/tb_countdown_timer_core.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/timer_defs.sv
// Shared definitions for the countdown timer: FSM state encoding, BCD digit
// limits and per-digit BCD helpers used by both the top level and the digit
// cells.
package timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_MIN = 4'd0;

  // Clamp a raw preset nibble to a legal BCD digit.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

  // One BCD step in the given direction, wrapping 9->0 (up) or 0->9 (down).
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    logic [3:0] r;
    if (up) r = (d >= DIGIT_MAX) ? DIGIT_MIN : d + 4'd1;
    else    r = (d == DIGIT_MIN) ? DIGIT_MAX : d - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// Single BCD digit register that steps up or down when enabled.
// Ports:
//   clk, rst_h    - clock, synchronous active-high reset
//   load          - reload q from load_val (reset does the same)
//   load_val      - value taken on reset/load
//   en            - step this digit on the next edge
//   up            - 1 = increment, 0 = decrement
//   q             - registered digit value
//   carry_borrow  - digit sits at its wrap point (9 going up, 0 going down)
module bcd_digit_updown
  import timer_defs::*;
(
  input  logic       clk,
  input  logic       rst_h,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] q,
  output logic       carry_borrow
);

  logic [3:0] q_q;

  always_ff @(posedge clk) begin
    if (rst_h || load) q_q <= load_val;
    else if (en)       q_q <= bcd_step(q_q, up);
  end

  assign q            = q_q;
  assign carry_borrow = up ? (q_q == DIGIT_MAX) : (q_q == DIGIT_MIN);

endmodule

// File: rtl/countdown_timer_core.sv
// N-digit BCD up/down timer with start/pause control and a status LED bar.
// Ports:
//   clk, rst_h   - clock, synchronous active-high reset
//   tick         - one-cycle count enable, honoured only in RUN
//   start_pause  - one-cycle pulse: IDLE->RUN/DONE, RUN<->PAUSE
//   load         - one-cycle pulse reloading from preset_bcd (ignored in RUN)
//   up_mode      - direction, captured on reset/load only
//   preset_bcd   - preset, digit 0 in bits [3:0]
//   count_bcd    - registered count
//   state        - FSM state (IDLE/RUN/PAUSE/DONE = 0/1/2/3)
//   done         - registered, high while in DONE
//   led          - registered status pattern
module countdown_timer_core
  import timer_defs::*;
#(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned LED_W      = 16,
  parameter bit          BLINK_DONE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_h,
  input  logic                  tick,
  input  logic                  start_pause,
  input  logic                  load,
  input  logic                  up_mode,
  input  logic [4*DIGITS-1:0]   preset_bcd,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [1:0]            state,
  output logic                  done,
  output logic [LED_W-1:0]      led
);

  localparam int unsigned CW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic              mode_q;
  logic [CW-1:0]     term_q, term_d;
  logic              done_q;
  logic [LED_W-1:0]  led_q, led_d;

  logic [CW-1:0]     preset_sat;
  logic [CW-1:0]     start_val;
  logic [CW-1:0]     cnt_nxt;
  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] cb;
  logic              load_eff;
  logic              tick_eff;

  assign load_eff = load && (state_q != ST_RUN);
  // A simultaneous start_pause takes priority, so the tick is dropped.
  assign tick_eff = tick && (state_q == ST_RUN) && !start_pause;

  // Start value and terminal use the incoming up_mode because the mode
  // register is captured on the same edge.
  assign start_val = up_mode ? '0 : preset_sat;
  assign term_d    = up_mode ? preset_sat : '0;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign preset_sat[4*k +: 4] = bcd_sat(preset_bcd[4*k +: 4]);

    // Digit k steps when ticked and every lower digit is at its wrap point;
    // written as a flat AND to keep the chain free of self-referencing nets.
    if (k == 0) begin : g_en0
      assign en[k] = tick_eff;
    end else begin : g_enk
      assign en[k] = tick_eff & (&cb[k-1:0]);
    end

    // Mirror of the digit's next value, used to detect the terminal edge.
    assign cnt_nxt[4*k +: 4] = en[k] ? bcd_step(count_bcd[4*k +: 4], mode_q)
                                     : count_bcd[4*k +: 4];

    bcd_digit_updown u_digit (
      .clk          (clk),
      .rst_h        (rst_h),
      .load         (load_eff),
      .load_val     (start_val[4*k +: 4]),
      .en           (en[k]),
      .up           (mode_q),
      .q            (count_bcd[4*k +: 4]),
      .carry_borrow (cb[k])
    );
  end

  always_comb begin
    state_d = state_q;
    if (load_eff) begin
      state_d = ST_IDLE;
    end else if (start_pause) begin
      unique case (state_q)
        ST_IDLE:  state_d = (count_bcd == term_q) ? ST_DONE : ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (tick_eff && (cnt_nxt == term_q)) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    led_d = led_q;
    unique case (state_d)
      ST_IDLE: led_d = '0;
      ST_RUN: begin
        led_d    = '0;
        led_d[0] = 1'b1;
      end
      ST_PAUSE: begin
        led_d    = '0;
        led_d[1] = 1'b1;
      end
      default: begin
        if (state_q != ST_DONE)     led_d = '1;
        else if (BLINK_DONE && tick) led_d = ~led_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      state_q <= ST_IDLE;
      mode_q  <= up_mode;
      term_q  <= term_d;
      done_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_DONE);
      led_q   <= led_d;
      if (load_eff) begin
        mode_q <= up_mode;
        term_q <= term_d;
      end
    end
  end

  assign state = state_q;
  assign done  = done_q;
  assign led   = led_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
module tb_countdown_timer_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 2 digits, 16 LEDs, blinking DONE
  logic        a_rst, a_tick, a_sp, a_ld, a_up;
  logic [7:0]  a_pre, a_cnt;
  logic [1:0]  a_st;
  logic        a_done;
  logic [15:0] a_led;

  // DUT B: 4 digits for the full borrow ripple
  logic        b_rst, b_tick, b_sp, b_ld, b_up;
  logic [15:0] b_pre, b_cnt;
  logic [1:0]  b_st;
  logic        b_done;
  logic [15:0] b_led;

  countdown_timer_core #(.DIGITS(2), .LED_W(16), .BLINK_DONE(1'b1)) u_dut_a (
    .clk(clk), .rst_h(a_rst), .tick(a_tick), .start_pause(a_sp), .load(a_ld),
    .up_mode(a_up), .preset_bcd(a_pre), .count_bcd(a_cnt), .state(a_st),
    .done(a_done), .led(a_led)
  );

  countdown_timer_core #(.DIGITS(4), .LED_W(16), .BLINK_DONE(1'b1)) u_dut_b (
    .clk(clk), .rst_h(b_rst), .tick(b_tick), .start_pause(b_sp), .load(b_ld),
    .up_mode(b_up), .preset_bcd(b_pre), .count_bcd(b_cnt), .state(b_st),
    .done(b_done), .led(b_led)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic        rst, ld, sp, tk, up;
    logic [7:0]  pre;
    logic [7:0]  cnt;
    logic [1:0]  st;
    logic        dn;
    logic [15:0] led;
  } vec_t;

  localparam int unsigned NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, ld, sp, tk, up, input logic [7:0] pre,
                              input logic [7:0] cnt, input logic [1:0] st,
                              input logic dn, input logic [15:0] led);
    vec_t v;
    v.rst = rst; v.ld = ld; v.sp = sp; v.tk = tk; v.up = up; v.pre = pre;
    v.cnt = cnt; v.st = st; v.dn = dn; v.led = led;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic rst, ld, sp, tk, up, input logic [7:0] pre);
    a_rst = rst; a_ld = ld; a_sp = sp; a_tick = tk; a_up = up; a_pre = pre;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic rst, ld, sp, tk, up, input logic [15:0] pre);
    b_rst = rst; b_ld = ld; b_sp = sp; b_tick = tk; b_up = up; b_pre = pre;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] e16;

    a_rst = 1'b1; a_ld = 1'b0; a_sp = 1'b0; a_tick = 1'b0; a_up = 1'b0; a_pre = 8'h30;
    b_rst = 1'b1; b_ld = 1'b0; b_sp = 1'b0; b_tick = 1'b0; b_up = 1'b0; b_pre = 16'h1000;

    //              rst ld sp tk up  pre     cnt    st    dn  led
    vecs[0]  = mk(1, 0, 0, 0, 0, 8'h30, 8'h30, 2'd0, 0, 16'h0000);
    vecs[1]  = mk(0, 0, 1, 0, 0, 8'h30, 8'h30, 2'd1, 0, 16'h0001);
    vecs[2]  = mk(0, 0, 0, 1, 0, 8'h30, 8'h29, 2'd1, 0, 16'h0001);
    vecs[3]  = mk(0, 0, 0, 1, 0, 8'h30, 8'h28, 2'd1, 0, 16'h0001);
    vecs[4]  = mk(0, 0, 1, 1, 0, 8'h30, 8'h28, 2'd2, 0, 16'h0002);
    vecs[5]  = mk(0, 0, 0, 1, 0, 8'h30, 8'h28, 2'd2, 0, 16'h0002);
    vecs[6]  = mk(0, 0, 0, 1, 0, 8'h30, 8'h28, 2'd2, 0, 16'h0002);
    vecs[7]  = mk(0, 0, 1, 0, 0, 8'h30, 8'h28, 2'd1, 0, 16'h0001);
    vecs[8]  = mk(0, 1, 0, 0, 0, 8'h50, 8'h28, 2'd1, 0, 16'h0001);
    vecs[9]  = mk(0, 0, 1, 0, 0, 8'h50, 8'h28, 2'd2, 0, 16'h0002);
    vecs[10] = mk(0, 1, 0, 0, 0, 8'hA5, 8'h95, 2'd0, 0, 16'h0000);
    vecs[11] = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 2'd0, 0, 16'h0000);
    vecs[12] = mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 2'd3, 1, 16'hFFFF);
    vecs[13] = mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 2'd3, 1, 16'h0000);
    vecs[14] = mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 2'd3, 1, 16'h0000);
    vecs[15] = mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 2'd3, 1, 16'hFFFF);
    vecs[16] = mk(0, 1, 0, 0, 1, 8'h12, 8'h00, 2'd0, 0, 16'h0000);
    vecs[17] = mk(0, 0, 1, 0, 1, 8'h12, 8'h00, 2'd1, 0, 16'h0001);
    vecs[18] = mk(0, 0, 0, 1, 1, 8'h12, 8'h01, 2'd1, 0, 16'h0001);
    vecs[19] = mk(0, 1, 0, 0, 0, 8'h17, 8'h01, 2'd1, 0, 16'h0001);
    vecs[20] = mk(0, 0, 0, 1, 0, 8'h17, 8'h02, 2'd1, 0, 16'h0001);
    vecs[21] = mk(1, 0, 0, 0, 0, 8'h17, 8'h17, 2'd0, 0, 16'h0000);
    vecs[22] = mk(0, 0, 1, 0, 0, 8'h17, 8'h17, 2'd1, 0, 16'h0001);
    vecs[23] = mk(0, 0, 1, 1, 0, 8'h17, 8'h17, 2'd2, 0, 16'h0002);
    vecs[24] = mk(0, 0, 1, 0, 0, 8'h17, 8'h17, 2'd1, 0, 16'h0001);

    for (int i = 0; i < NV; i++) begin
      drive_a(vecs[i].rst, vecs[i].ld, vecs[i].sp, vecs[i].tk, vecs[i].up, vecs[i].pre);
      chk($sformatf("row%0d count", i), 32'(a_cnt),  32'(vecs[i].cnt));
      chk($sformatf("row%0d state", i), 32'(a_st),   32'(vecs[i].st));
      chk($sformatf("row%0d done", i),  32'(a_done), 32'(vecs[i].dn));
      chk($sformatf("row%0d led", i),   32'(a_led),  32'(vecs[i].led));
    end

    // Full countdown 30 -> 0, then LED blink in DONE.
    drive_a(1, 0, 0, 0, 0, 8'h30);
    drive_a(0, 0, 1, 0, 0, 8'h30);
    for (int i = 1; i <= 30; i++) begin
      drive_a(0, 0, 0, 1, 0, 8'h30);
      e16 = to_bcd(30 - i);
      chk($sformatf("down tick%0d count", i), 32'(a_cnt), 32'(e16[7:0]));
      chk($sformatf("down tick%0d state", i), 32'(a_st), (i == 30) ? 32'd3 : 32'd1);
    end
    chk("down final led", 32'(a_led), 32'hFFFF);
    chk("down final done", 32'(a_done), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      drive_a(0, 0, 0, 1, 0, 8'h30);
      chk($sformatf("blink%0d led", j), 32'(a_led), (j % 2 == 1) ? 32'h0000 : 32'hFFFF);
      chk($sformatf("blink%0d count", j), 32'(a_cnt), 32'h00);
    end

    // Up mode 0 -> 12 with carry into the tens digit.
    drive_a(0, 1, 0, 0, 1, 8'h12);
    chk("up load count", 32'(a_cnt), 32'h00);
    drive_a(0, 0, 1, 0, 1, 8'h12);
    chk("up start state", 32'(a_st), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      drive_a(0, 0, 0, 1, 1, 8'h12);
      e16 = to_bcd(i);
      chk($sformatf("up tick%0d count", i), 32'(a_cnt), 32'(e16[7:0]));
      chk($sformatf("up tick%0d state", i), 32'(a_st), (i == 12) ? 32'd3 : 32'd1);
    end
    chk("up done", 32'(a_done), 32'd1);

    // Four-digit borrow ripple and mid-run reset.
    drive_b(1, 0, 0, 0, 0, 16'h1000);
    chk("b reset count", 32'(b_cnt), 32'h1000);
    chk("b reset state", 32'(b_st), 32'd0);
    drive_b(0, 0, 1, 0, 0, 16'h1000);
    chk("b start state", 32'(b_st), 32'd1);
    drive_b(0, 0, 0, 1, 0, 16'h1000);
    chk("b ripple count", 32'(b_cnt), 32'h0999);
    drive_b(0, 0, 0, 1, 0, 16'h1000);
    chk("b tick2 count", 32'(b_cnt), 32'h0998);
    chk("b tick2 done", 32'(b_done), 32'd0);
    drive_b(1, 0, 0, 1, 0, 16'h1000);
    chk("b midrun reset count", 32'(b_cnt), 32'h1000);
    chk("b midrun reset state", 32'(b_st), 32'd0);
    chk("b midrun reset led", 32'(b_led), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
